// File: rtl/input_port_unit.sv
// ============================================================================
// Module      : input_port_unit
// Description : Input FIFO plus XY route computation for one mesh router port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OUT_LOCAL_PORT
`define OUT_LOCAL_PORT 3'd0
`endif
`ifndef OUT_X1_PORT
`define OUT_X1_PORT 3'd1
`endif
`ifndef OUT_Y1_PORT
`define OUT_Y1_PORT 3'd2
`endif

module input_port_unit #(
  parameter int FLIT_W  = 16,
  parameter int DEPTH   = 4,
  parameter int X_W     = 2,
  parameter int Y_W     = 1,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [FLIT_W-1:0]      in_flit,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [FLIT_W-1:0]      out_flit,
  output logic [2:0]             out_dst,
  input  logic                   grant,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_rt_w  = X_W + Y_W;

  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [X_W-1:0]     c_local_x = X_W'(LOCAL_X);
  localparam logic [Y_W-1:0]     c_local_y = Y_W'(LOCAL_Y);
  localparam logic [2:0]         c_no_req  = 3'b111;

  logic [FLIT_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [2:0]         r_out_dst;

  logic               w_push;
  logic               w_pop;
  logic [c_ptr_w-1:0] w_rd_ptr_nxt;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic [c_rt_w-1:0]  w_head_rt;
  logic [X_W-1:0]     w_dst_x;
  logic [Y_W-1:0]     w_dst_y;
  logic [2:0]         w_dst_nxt;

  assign in_ready  = (r_count != c_depth);
  assign out_valid = (r_count != '0);
  assign out_flit  = r_mem[r_rd_ptr];
  assign out_dst   = r_out_dst;
  assign count     = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = grant & en & out_valid;

  always_comb begin
    w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
    w_count_nxt  = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_one;
      2'b01:   w_count_nxt = r_count - c_cnt_one;
      default: w_count_nxt = r_count;
    endcase
  end

  // Next head is the flit being written now only when the FIFO drains to it this edge.
  always_comb begin
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_rt = in_flit[FLIT_W-1 -: c_rt_w];
    end else begin
      w_head_rt = r_mem[w_rd_ptr_nxt][FLIT_W-1 -: c_rt_w];
    end
    w_dst_x = w_head_rt[c_rt_w-1 -: X_W];
    w_dst_y = w_head_rt[Y_W-1:0];
  end

  always_comb begin
    w_dst_nxt = c_no_req;
    if (w_count_nxt == '0) begin
      w_dst_nxt = c_no_req;
    end else if (w_dst_x != c_local_x) begin
      w_dst_nxt = `OUT_X1_PORT;
    end else if (w_dst_y != c_local_y) begin
      w_dst_nxt = `OUT_Y1_PORT;
    end else begin
      w_dst_nxt = `OUT_LOCAL_PORT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_dst <= c_no_req;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_out_dst <= w_dst_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_flit;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_input_port_unit.sv
// ============================================================================
// Module      : tb_input_port_unit
// Description : Directed self-checking bench for input_port_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OUT_LOCAL_PORT
`define OUT_LOCAL_PORT 3'd0
`endif
`ifndef OUT_X1_PORT
`define OUT_X1_PORT 3'd1
`endif
`ifndef OUT_Y1_PORT
`define OUT_Y1_PORT 3'd2
`endif

module tb_input_port_unit;

  localparam logic [2:0] c_x1   = `OUT_X1_PORT;
  localparam logic [2:0] c_y1   = `OUT_Y1_PORT;
  localparam logic [2:0] c_loc  = `OUT_LOCAL_PORT;
  localparam logic [2:0] c_none = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [15:0] in_flit;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_flit;
  logic [2:0]  out_dst;
  logic        grant;
  logic [2:0]  count;

  int total;
  int bad;

  input_port_unit #(
    .FLIT_W(16), .DEPTH(4), .X_W(2), .Y_W(1), .LOCAL_X(0), .LOCAL_Y(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_flit(in_flit),
    .in_ready(in_ready), .out_valid(out_valid), .out_flit(out_flit),
    .out_dst(out_dst), .grant(grant), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] f);
    in_valid = 1'b1;
    in_flit  = f;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    grant = 1'b1;
    tick();
    grant = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [15:0] f, input logic [2:0] d);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_flit"}, 32'(out_flit), 32'(f));
    check({tag, "_dst"}, 32'(out_dst), 32'(d));
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_dst"}, 32'(out_dst), 32'(c_none));
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    in_flit  = '0;
    grant    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    expect_empty("por");

    // Asynchronous reset mid-run with three entries held
    push(16'hC000);
    push(16'h2000);
    push(16'h0123);
    check("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    expect_empty("async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    // XY routing of three distinct heads
    in_valid = 1'b1;
    in_flit  = 16'hC000;
    tick();
    expect_head("lat1", 16'hC000, c_x1);
    in_flit = 16'h2000;
    tick();
    in_flit = 16'h0123;
    tick();
    in_valid = 1'b0;
    check("route_count", 32'(count), 32'd3);
    expect_head("hold_x1", 16'hC000, c_x1);
    pop();
    expect_head("route_y1", 16'h2000, c_y1);
    pop();
    expect_head("route_loc", 16'h0123, c_loc);
    pop();
    expect_empty("route_drain");

    // Full FIFO back-pressure and ordering
    push(16'h0002);
    push(16'h2003);
    push(16'h8004);
    push(16'h4001);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_flit  = 16'h0005;
    tick();
    check("full_hold_count", 32'(count), 32'd4);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_ready", 32'(in_ready), 32'd1);
    expect_head("full_h2", 16'h2003, c_y1);
    tick();
    in_valid = 1'b0;
    check("full_refill", 32'(count), 32'd4);
    pop();
    expect_head("full_h3", 16'h8004, c_x1);
    pop();
    expect_head("full_h4", 16'h4001, c_x1);
    pop();
    expect_head("full_h5", 16'h0005, c_loc);
    pop();
    expect_empty("full_drain");

    // Simultaneous push and pop
    push(16'h0011);
    push(16'h4012);
    in_valid = 1'b1;
    in_flit  = 16'h2013;
    grant    = 1'b1;
    tick();
    in_valid = 1'b0;
    grant    = 1'b0;
    check("pp_count", 32'(count), 32'd2);
    expect_head("pp_head", 16'h4012, c_x1);
    pop();
    in_valid = 1'b1;
    in_flit  = 16'h0014;
    grant    = 1'b1;
    tick();
    in_valid = 1'b0;
    grant    = 1'b0;
    check("pp1_count", 32'(count), 32'd1);
    expect_head("pp1_head", 16'h0014, c_loc);
    pop();
    expect_empty("pp_drain");

    // Grant on empty FIFO is ignored
    grant = 1'b1;
    tick();
    tick();
    tick();
    grant = 1'b0;
    expect_empty("empty_grant");
    push(16'h2021);
    check("empty_grant_count", 32'(count), 32'd1);
    expect_head("empty_grant_head", 16'h2021, c_y1);
    pop();

    // Enable gating: push while disabled, pops blocked
    en       = 1'b0;
    grant    = 1'b1;
    in_valid = 1'b1;
    in_flit  = 16'h6031;
    tick();
    in_valid = 1'b0;
    tick();
    check("en0_count", 32'(count), 32'd1);
    expect_head("en0_head", 16'h6031, c_x1);
    en = 1'b1;
    tick();
    grant = 1'b0;
    expect_empty("en1_pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
